// File: rtl/wb_pkg.sv
// wb_pkg: shared constants and helpers for the white-balance gain path
package wb_pkg;
  localparam int G_SLOT = 0;
  localparam int B_SLOT = 1;
  localparam int R_SLOT = 2;
  typedef struct packed {
    logic user;
    logic last;
  } side_t;
  function automatic int unsigned fixed_one(input int unsigned fract_width);
    return 32'd1 << fract_width;
  endfunction
endpackage

// File: rtl/axi4_stream_if.sv
// axi4_stream_if: minimal AXI4-Stream video link with frame-start and end-of-line sideband
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 30
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tuser;
  logic                  tlast;
  modport master (output tdata, tvalid, tuser, tlast, input tready);
  modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/wb_chan_gain.sv
// wb_chan_gain: one colour channel, multiply (S2) then round and saturate (S3)
module wb_chan_gain #(
  parameter int PX_WIDTH    = 10,
  parameter int FRACT_WIDTH = 10,
  parameter int COEF_WIDTH  = PX_WIDTH + FRACT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic [PX_WIDTH-1:0]   px_i,
  input  logic [COEF_WIDTH-1:0] gain_i,
  output logic [PX_WIDTH-1:0]   px_o
);
  localparam int PW = PX_WIDTH + COEF_WIDTH;
  localparam logic [PW:0] HALF = (PW+1)'(1) << (FRACT_WIDTH - 1);
  localparam logic [PW:0] MAX  = (PW+1)'((1 << PX_WIDTH) - 1);
  logic [PW-1:0]       prod_d, prod_q;
  logic [PW:0]         rnd;
  logic [PX_WIDTH-1:0] px_d, px_q;
  always_comb begin
    prod_d = en_i ? PW'(px_i) * PW'(gain_i) : prod_q;
    rnd    = ({1'b0, prod_q} + HALF) >> FRACT_WIDTH;
    px_d   = en_i ? (rnd > MAX ? {PX_WIDTH{1'b1}} : rnd[PX_WIDTH-1:0]) : px_q;
  end
  always_ff @(posedge clk_i) begin
    prod_q <= prod_d;
    px_q   <= px_d;
  end
  assign px_o = px_q;
endmodule

// File: rtl/wb_gain_apply.sv
// wb_gain_apply: per-frame R/B white-balance gains applied to an RBG video stream
module wb_gain_apply
  import wb_pkg::*;
#(
  parameter int PX_WIDTH    = 10,
  parameter int FRACT_WIDTH = 10,
  parameter int COEF_WIDTH  = PX_WIDTH + FRACT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  axi4_stream_if.slave          video_i,
  axi4_stream_if.master         video_o,
  input  logic [COEF_WIDTH-1:0] r_corr_i,
  input  logic [COEF_WIDTH-1:0] b_corr_i,
  input  logic                  bypass_i
);
  localparam logic [COEF_WIDTH-1:0] ONE = COEF_WIDTH'(fixed_one(FRACT_WIDTH));
  logic                          en, acc, sof;
  logic [COEF_WIDTH-1:0]         r_sel, b_sel;
  logic [COEF_WIDTH-1:0]         r_act_d, r_act_q, b_act_d, b_act_q;
  logic [COEF_WIDTH-1:0]         rg1_d, rg1_q, bg1_d, bg1_q;
  logic [PX_WIDTH-1:0]           r1_d, r1_q, b1_d, b1_q, r3, b3;
  logic [2:0][PX_WIDTH-1:0]      g_d, g_q;
  side_t [2:0]                   s_d, s_q;
  logic [2:0]                    v_d, v_q;
  always_comb begin
    en      = !v_q[2] || video_o.tready;
    acc     = video_i.tvalid && en;
    sof     = video_i.tvalid && video_i.tuser;
    // a frame-start beat already uses the gains it loads
    r_sel   = sof ? (bypass_i ? ONE : r_corr_i) : r_act_q;
    b_sel   = sof ? (bypass_i ? ONE : b_corr_i) : b_act_q;
    r_act_d = acc ? r_sel : r_act_q;
    b_act_d = acc ? b_sel : b_act_q;
    v_d     = en ? {v_q[1:0], video_i.tvalid} : v_q;
    r1_d    = en ? video_i.tdata[R_SLOT*PX_WIDTH +: PX_WIDTH] : r1_q;
    b1_d    = en ? video_i.tdata[B_SLOT*PX_WIDTH +: PX_WIDTH] : b1_q;
    rg1_d   = en ? r_sel : rg1_q;
    bg1_d   = en ? b_sel : bg1_q;
    g_d     = en ? {g_q[1:0], video_i.tdata[G_SLOT*PX_WIDTH +: PX_WIDTH]} : g_q;
    s_d     = en ? {s_q[1:0], side_t'({video_i.tuser, video_i.tlast})} : s_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q     <= '0;
      r_act_q <= ONE;
      b_act_q <= ONE;
    end else begin
      v_q     <= v_d;
      r_act_q <= r_act_d;
      b_act_q <= b_act_d;
    end
  end
  always_ff @(posedge clk_i) begin
    r1_q  <= r1_d;
    b1_q  <= b1_d;
    rg1_q <= rg1_d;
    bg1_q <= bg1_d;
    g_q   <= g_d;
    s_q   <= s_d;
  end
  wb_chan_gain #(.PX_WIDTH(PX_WIDTH), .FRACT_WIDTH(FRACT_WIDTH), .COEF_WIDTH(COEF_WIDTH)) u_r (
    .clk_i(clk_i), .en_i(en), .px_i(r1_q), .gain_i(rg1_q), .px_o(r3)
  );
  wb_chan_gain #(.PX_WIDTH(PX_WIDTH), .FRACT_WIDTH(FRACT_WIDTH), .COEF_WIDTH(COEF_WIDTH)) u_b (
    .clk_i(clk_i), .en_i(en), .px_i(b1_q), .gain_i(bg1_q), .px_o(b3)
  );
  // upstream may always push during reset; whatever it sends is discarded
  assign video_i.tready = en || rst_i;
  assign video_o.tvalid = v_q[2];
  assign video_o.tdata  = {r3, b3, g_q[2]};
  assign video_o.tuser  = s_q[2].user;
  assign video_o.tlast  = s_q[2].last;
endmodule
